// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out framing transmitter: start bit, data LSB-first, optional parity, stop bit.
// Each bit is held for BIT_CYCLES clocks; the line is registered and idles high.
module piso_serial_tx #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned BIT_CYCLES = 1,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serialout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned   CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int unsigned   IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CycLast   = CW'(BIT_CYCLES - 1);
   localparam logic [IW-1:0] IdxLast   = IW'(WIDTH - 1);
   localparam logic          ParOdd    = (PARITY_ODD != 0);
   localparam logic          HasParity = (PARITY_EN != 0);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

   state_t           state;
   logic [CW-1:0]    cyc;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted;
   logic             par;
   logic             bit_end;

   assign load_ready = (state == StIdle) && !reset;
   assign bit_end    = (cyc == CycLast);
   assign shifted    = shreg >> 1;

   // Outputs are registered alongside the state so the line changes one clock after each decision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         cyc       <= '0;
         idx       <= '0;
         shreg     <= '0;
         par       <= 1'b0;
         serialout <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state != StIdle) begin
            cyc <= bit_end ? '0 : cyc + CW'(1);
         end
         case (state)
            StIdle: begin
               if (load_valid && load_ready) begin
                  shreg     <= data_in;
                  par       <= (^data_in) ^ ParOdd;
                  state     <= StStart;
                  serialout <= 1'b0;
                  busy      <= 1'b1;
                  cyc       <= '0;
               end
            end
            StStart: begin
               if (bit_end) begin
                  state     <= StData;
                  idx       <= '0;
                  serialout <= shreg[0];
               end
            end
            StData: begin
               if (bit_end) begin
                  shreg <= shifted;
                  if (idx == IdxLast) begin
                     if (HasParity) begin
                        state     <= StParity;
                        serialout <= par;
                     end else begin
                        state     <= StStop;
                        serialout <= 1'b1;
                     end
                  end else begin
                     idx       <= idx + IW'(1);
                     serialout <= shifted[0];
                  end
               end
            end
            StParity: begin
               if (bit_end) begin
                  state     <= StStop;
                  serialout <= 1'b1;
               end
            end
            StStop: begin
               if (bit_end) begin
                  state <= StIdle;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: four parameterisations driven side by side, checked every cycle
// against a frame-queue model, plus literal line patterns from hand-worked frames.
module tb_piso_serial_tx;

   localparam int N = 4;
   // Instance configs: 0 = (B1, parity even), 1 = (B1, no parity, odd), 2 = (B3, even), 3 = (B1, odd)
   localparam logic [N-1:0] PE_V = 4'b1101;
   localparam logic [N-1:0] PO_V = 4'b1010;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] data_in    [N];
   logic       load_valid [N];
   logic       load_ready [N];
   logic       serialout  [N];
   logic       busy       [N];
   logic       done       [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      piso_serial_tx #(
         .WIDTH      (4),
         .BIT_CYCLES ((g == 2) ? 3 : 1),
         .PARITY_EN  (int'(PE_V[g])),
         .PARITY_ODD (int'(PO_V[g]))
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .data_in    (data_in[g]),
         .load_valid (load_valid[g]),
         .load_ready (load_ready[g]),
         .serialout  (serialout[g]),
         .busy       (busy[g]),
         .done       (done[g])
      );
   end

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit mq [N][$];
   bit exp_line [N];
   bit exp_busy [N];
   bit exp_done [N];
   logic ln [N][64];
   logic dn [N][64];

   function automatic int bc(int i);
      return (i == 2) ? 3 : 1;
   endfunction

   task automatic chk(input string nm, input int inst, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %b, expected %b", nm, inst, $time, act, exp);
      end
   endtask

   task automatic chk_vec(input string nm, input int inst, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %b, expected %b", nm, inst, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         mq[i].delete();
         exp_line[i] = 1'b1;
         exp_busy[i] = 1'b0;
         exp_done[i] = 1'b0;
      end
   endtask

   // Frame as a list of per-clock line values; the model just plays it out.
   task automatic push_frame(input int i, input logic [3:0] d);
      bit b [$];
      b.push_back(1'b0);
      for (int k = 0; k < 4; k++) b.push_back(d[k]);
      if (PE_V[i]) b.push_back((^d) ^ PO_V[i]);
      b.push_back(1'b1);
      foreach (b[k]) for (int r = 0; r < bc(i); r++) mq[i].push_back(b[k]);
   endtask

   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            mq[i].delete();
            exp_line[i] = 1'b1;
            exp_busy[i] = 1'b0;
            exp_done[i] = 1'b0;
         end else begin
            if (!exp_busy[i] && load_valid[i]) push_frame(i, data_in[i]);
            if (mq[i].size() > 0) begin
               exp_line[i] = mq[i].pop_front();
               exp_done[i] = 1'b0;
               exp_busy[i] = 1'b1;
            end else begin
               exp_done[i] = exp_busy[i];
               exp_busy[i] = 1'b0;
               exp_line[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < N; i++) begin
         chk("serialout", i, serialout[i], exp_line[i]);
         chk("busy", i, busy[i], exp_busy[i]);
         chk("done", i, done[i], exp_done[i]);
         chk("load_ready", i, load_ready[i], !exp_busy[i] && !reset);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   // Sample j (1-based) is cycle T+j when the word is accepted on the first edge.
   task automatic capture(input int n, input bit drop_valid);
      for (int j = 1; j <= n; j++) begin
         step();
         for (int i = 0; i < N; i++) begin
            ln[i][j] = serialout[i];
            dn[i][j] = done[i];
            if (drop_valid) load_valid[i] = 1'b0;
         end
      end
   endtask

   function automatic logic [31:0] pk(int i, int n);
      logic [31:0] v = '0;
      for (int j = 1; j <= n; j++) v = {v[30:0], ln[i][j]};
      return v;
   endfunction

   function automatic logic [31:0] first_done(int i, int n);
      for (int j = 1; j <= n; j++) if (dn[i][j] === 1'b1) return 32'(j);
      return 32'd0;
   endfunction

   task automatic idle_all();
      for (int i = 0; i < N; i++) load_valid[i] = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         data_in[i]    = '0;
         load_valid[i] = 1'b0;
      end
      model_clear();
      #1;
      compare_all();
      repeat (2) step();
      reset = 1'b0;
      repeat (2) step();

      // Hand-worked frames on every instance at once
      data_in[0] = 4'b1011;
      data_in[1] = 4'b0000;
      data_in[2] = 4'b0001;
      data_in[3] = 4'b0000;
      for (int i = 0; i < N; i++) load_valid[i] = 1'b1;
      capture(24, 1'b1);
      chk_vec("frame_basic", 0, pk(0, 8), 32'b0110_1111);
      chk_vec("done_basic", 0, first_done(0, 24), 32'd8);
      chk_vec("frame_noparity", 1, pk(1, 7), 32'b000_0011);
      chk_vec("done_noparity", 1, first_done(1, 24), 32'd7);
      chk_vec("frame_stretch", 2, pk(2, 22), 32'b000_111_000000000_111111_1);
      chk_vec("done_stretch", 2, first_done(2, 24), 32'd22);
      chk_vec("frame_oddparity", 3, pk(3, 8), 32'b0000_0111);
      chk_vec("done_oddparity", 3, first_done(3, 24), 32'd8);

      // Back-to-back with load_valid held and data_in changed mid-frame
      data_in[0]    = 4'hA;
      load_valid[0] = 1'b1;
      for (int j = 1; j <= 16; j++) begin
         step();
         ln[0][j] = serialout[0];
         if (j == 2) data_in[0] = 4'h5;
      end
      load_valid[0] = 1'b0;
      chk_vec("frame_b2b", 0, pk(0, 16), 32'b0010101_1_0101001_1);
      repeat (10) step();

      // Reset during data bit 2 of a frame, then a clean frame afterwards
      data_in[0]    = 4'b1011;
      load_valid[0] = 1'b1;
      step();
      load_valid[0] = 1'b0;
      repeat (3) step();
      chk("pre_reset_line", 0, serialout[0], 1'b0);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_line", 0, serialout[0], 1'b1);
      chk("async_reset_busy", 0, busy[0], 1'b0);
      chk("async_reset_ready", 0, load_ready[0], 1'b0);
      model_clear();
      @(negedge clk);
      compare_all();
      step();
      reset = 1'b0;
      capture(3, 1'b1);
      chk_vec("no_done_after_reset", 0, first_done(0, 3), 32'd0);
      data_in[0]    = 4'h3;
      load_valid[0] = 1'b1;
      capture(8, 1'b1);
      chk_vec("frame_after_reset", 0, pk(0, 8), 32'b0110_0011);
      chk_vec("done_after_reset", 0, first_done(0, 8), 32'd8);

      // Randomised traffic with occasional asynchronous resets
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            load_valid[i] = ($urandom_range(0, 2) != 0);
            data_in[i]    = 4'($urandom);
         end
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            model_clear();
         end
         step();
      end
      reset = 1'b0;
      idle_all();
      repeat (30) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
